approx_rca_pipe: RTL and testbench
==================================

Name: approx_rca_pipe

Overview:
- Parametrised, pipelined ripple-carry adder; the successor to the fixed 8-bit compressor/approximate-cell adder.
- Adds two WIDTH-bit operands in SEG_WIDTH-bit ripple segments, with one register stage per segment.
- A per-transaction mode bit selects either the exact sum or a lower-part-OR approximate sum over the APPROX_BITS LSBs.
- Valid/ready handshake on both sides; sits in datapath/arithmetic experiments as a drop-in accumulating adder.

Parameters:
- WIDTH, 16: operand and sum width; must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 4: bits resolved per pipeline stage. STAGES = WIDTH/SEG_WIDTH.
- APPROX_BITS, 4: LSBs handled approximately in approx mode; range 0..WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; used in exact mode only
- approx_en  in  1  1 = approximate mode for this transaction
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out of the MSB
- out_approx  out  1  mode bit of the transaction currently on sum

Behaviour:
- Reset (async assert, sync release): all stage valid bits, partial-sum, carry, skewed-operand and mode registers = 0. Outputs: out_valid=0, sum=0, cout=0, out_approx=0. in_ready=1 while rst_n is high.
- Global advance: adv = !out_valid || out_ready; in_ready = adv.
  - Handshake fires when in_valid && in_ready.
  - When adv=0, every stage register holds, including bubbles.
  - Bubbles are not collapsed.
- Stage k (0..STAGES-1), on adv:
  - Ripples bits [k*SEG_WIDTH +: SEG_WIDTH] with the carry registered by stage k-1; stage 0 uses the effective carry-in.
  - Registers the segment sum, the carry-out, the valid bit and the mode bit.
  - Remaining upper operand bits are skewed forward in registers.
  - Lower sum bits already computed are carried along.
- Latency: a result appears on sum exactly STAGES cycles after acceptance when no stall occurs. Throughput is 1 per cycle.
- Exact mode (approx_en=0): {cout,sum} = a + b + cin, full WIDTH+1 bits.
- Approximate mode (approx_en=1), K = APPROX_BITS:
  - sum[i] = a[i] | b[i] for i < K.
  - Carry into bit K = a[K-1] & b[K-1]; when K=0 it is 0.
  - cin is ignored.
  - Bits K..WIDTH-1 and cout are exact ripple from that carry.
  - K=WIDTH gives sum = a|b and cout = a[W-1]&b[W-1].
- Segments straddling K mix OR bits and ripple bits within one stage. Mode travels with the data and may differ on every cycle.
- Output held stable (sum, cout, out_approx, out_valid) while out_valid && !out_ready.
- Simultaneous accept and emit with out_ready=1: both occur and the pipeline shifts.
- Reset mid-operation discards all in-flight transactions. No partial result is ever emitted.
- Elaboration must fail (generate-time check) if WIDTH % SEG_WIDTH != 0 or APPROX_BITS > WIDTH.

Test Plan:
All scenarios use defaults WIDTH=16, SEG_WIDTH=4, APPROX_BITS=4 (STAGES=4).
1. Exact add:
   - Stimulus: a=0x00B5, b=0x00ED, cin=0, approx_en=0, out_ready=1.
   - Required: 4 cycles later sum=0x01A2, cout=0, out_approx=0, out_valid for exactly 1 cycle.
2. Same operands with approx_en=1:
   - Required: sum=0x019D, cout=0, out_approx=1.
   - Then a=0xFFFF, b=0x0001, approx_en=1 → sum=0xFFFF, cout=0.
   - Same operands exact → sum=0x0000, cout=1.
3. Carry-in handling:
   - a=0x7FFF, b=0x0000, cin=1, exact → sum=0x8000, cout=0.
   - Same operands with approx_en=1 → sum=0x7FFF (cin ignored).
4. Back-to-back mixed modes:
   - Stimulus: 8 consecutive accepted transactions alternating approx_en.
   - Required: 8 consecutive out_valid cycles starting at cycle 4, in order, each with correct out_approx and value (checked against a reference model).
5. Backpressure:
   - Stimulus: push 6 transactions, drive out_ready=0 from first out_valid for 5 cycles.
   - Required: in_ready=0 throughout the stall; sum/cout held constant.
   - After release: the remaining results appear in order, none dropped or duplicated.
6. Reset mid-flight:
   - Stimulus: accept 3 transactions, assert rst_n=0 asynchronously between edges.
   - Required: out_valid=0 and sum=0 immediately; after release, no stale result ever appears.
   - A new transaction 0x0001+0x0001 returns 0x0002 after 4 cycles.

Source files
------------

// File: rtl/approx_rca_pipe.sv
// approx_rca_pipe: segmented, pipelined ripple-carry adder with a
// per-transaction lower-part-OR approximate mode.
module approx_rca_pipe #(
  parameter int WIDTH       = 16,
  parameter int SEG_WIDTH   = 4,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_approx
);
  localparam int STAGES = WIDTH / SEG_WIDTH;

  if (WIDTH % SEG_WIDTH != 0 || APPROX_BITS > WIDTH) begin : g_bad_params
    $error("approx_rca_pipe: illegal WIDTH/SEG_WIDTH/APPROX_BITS");
  end

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SEG_WIDTH;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]          x, y;
    logic                    c_in, m, v;
    logic [SEG_WIDTH:0]      c;
    logic [SEG_WIDTH-1:0]    s;
    logic [LO+SEG_WIDTH-1:0] p_n, p_q;
    logic                    c_q, m_q, v_q;

    // cin only feeds exact transactions; approx ones start from zero
    if (k == 0) begin : g_head
      assign x    = a;
      assign y    = b;
      assign c_in = cin & ~approx_en;
      assign m    = approx_en;
      assign v    = in_valid;
      assign p_n  = s;
    end else begin : g_tail
      assign x    = g_stage[k-1].g_fwd.x_q;
      assign y    = g_stage[k-1].g_fwd.y_q;
      assign c_in = g_stage[k-1].c_q;
      assign m    = g_stage[k-1].m_q;
      assign v    = g_stage[k-1].v_q;
      assign p_n  = {s, g_stage[k-1].p_q};
    end

    assign c[0] = c_in;

    for (genvar j = 0; j < SEG_WIDTH; j++) begin : g_bit
      localparam int I = LO + j;
      logic p, g;

      assign p = x[j] ^ y[j];
      assign g = x[j] & y[j];

      if (I < APPROX_BITS) begin : g_mix
        logic c_or;
        // only the top OR bit generates the carry into the exact part
        if (I == APPROX_BITS - 1) begin : g_top
          assign c_or = g;
        end else begin : g_low
          assign c_or = 1'b0;
        end
        assign s[j]   = m ? (x[j] | y[j]) : (p ^ c[j]);
        assign c[j+1] = m ? c_or : (g | (p & c[j]));
      end else begin : g_exact
        assign s[j]   = p ^ c[j];
        assign c[j+1] = g | (p & c[j]);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        m_q <= 1'b0;
        c_q <= 1'b0;
        p_q <= '0;
      end else if (adv) begin
        v_q <= v;
        m_q <= m;
        c_q <= c[SEG_WIDTH];
        p_q <= p_n;
      end
    end

    if (REM > SEG_WIDTH) begin : g_fwd
      logic [REM-SEG_WIDTH-1:0] x_q, y_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q <= '0;
          y_q <= '0;
        end else if (adv) begin
          x_q <= x[REM-1:SEG_WIDTH];
          y_q <= y[REM-1:SEG_WIDTH];
        end
      end
    end
  end

  assign out_valid  = g_stage[STAGES-1].v_q;
  assign out_approx = g_stage[STAGES-1].m_q;
  assign cout       = g_stage[STAGES-1].c_q;
  assign sum        = g_stage[STAGES-1].p_q;

endmodule

// File: tb/tb_approx_rca_pipe.sv
// tb_approx_rca_pipe: directed and randomized checks of approx_rca_pipe
// against an arithmetic reference model.
module tb_approx_rca_pipe;
  localparam int W  = 16;
  localparam int SW = 4;
  localparam int K  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         approx_en = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_approx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  approx_rca_pipe #(
    .WIDTH(W), .SEG_WIDTH(SW), .APPROX_BITS(K)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx_en(approx_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .out_approx(out_approx)
  );

  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic ci,
                                       input logic m);
    longint unsigned xl, yl, lo, hi, cy, r;
    xl = 64'(x);
    yl = 64'(y);
    if (!m) begin
      r = xl + yl + 64'(ci);
    end else begin
      lo = (xl | yl) & ((64'd1 << K) - 1);
      cy = (K == 0) ? 0 : ((xl >> (K - 1)) & (yl >> (K - 1)) & 1);
      hi = ((xl >> K) + (yl >> K) + cy) << K;
      r  = hi | lo;
    end
    return r[W:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    approx_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    out_ready = 1'b1;
    #12;
    checks += 4;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    if (sum !== '0) begin
      errors++; $display("FAIL reset_sum got %h want 0000", sum);
    end
    if (cout !== 1'b0) begin
      errors++; $display("FAIL reset_cout got %b want 0", cout);
    end
    if (out_approx !== 1'b0) begin
      errors++; $display("FAIL reset_out_approx got %b want 0", out_approx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'h00B5, 16'h00B5, 16'hFFFF,
                             16'hFFFF, 16'h7FFF, 16'h7FFF};
    logic [W-1:0] tb [6] = '{16'h00ED, 16'h00ED, 16'h0001,
                             16'h0001, 16'h0000, 16'h0000};
    logic tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic tm [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] es [6] = '{16'h01A2, 16'h019D, 16'hFFFF,
                             16'h0000, 16'h8000, 16'h7FFF};
    logic ec [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 6; t++) begin
      a = ta[t]; b = tb[t]; cin = tc[t]; approx_en = tm[t];
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      idle();
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== (c == 4)) begin
          errors++;
          $display("FAIL dir%0d_valid_c%0d got %b want %b",
                   t, c, out_valid, (c == 4));
        end
        if (c == 4) begin
          checks += 3;
          if (sum !== es[t]) begin
            errors++; $display("FAIL dir%0d_sum got %h want %h", t, sum, es[t]);
          end
          if (cout !== ec[t]) begin
            errors++; $display("FAIL dir%0d_cout got %b want %b", t, cout, ec[t]);
          end
          if (out_approx !== tm[t]) begin
            errors++;
            $display("FAIL dir%0d_approx got %b want %b", t, out_approx, tm[t]);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] er [8];
    logic       em [8];
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        a = W'($urandom); b = W'($urandom);
        cin = 1'($urandom); approx_en = 1'(c % 2);
        in_valid = 1'b1;
        er[c] = model(a, b, cin, approx_en);
        em[c] = approx_en;
      end else begin
        idle();
      end
      @(negedge clk);
      checks += 2;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_in_ready_c%0d got %b want 1", c, in_ready);
      end
      if (out_valid !== (c >= 4 && c < 12)) begin
        errors++;
        $display("FAIL b2b_valid_c%0d got %b want %b", c, out_valid,
                 (c >= 4 && c < 12));
      end
      if (c >= 4 && c < 12) begin
        checks += 2;
        if ({cout, sum} !== er[c-4]) begin
          errors++;
          $display("FAIL b2b_result_%0d got %h want %h", c - 4,
                   {cout, sum}, er[c-4]);
        end
        if (out_approx !== em[c-4]) begin
          errors++;
          $display("FAIL b2b_approx_%0d got %b want %b", c - 4,
                   out_approx, em[c-4]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] q [$];
    logic [W-1:0] ta [6], tb [6];
    logic         tc [6], tm [6];
    int sent = 0, got = 0, stall_left = 0, cyc = 0;
    bit started = 0;
    for (int i = 0; i < 6; i++) begin
      ta[i] = W'($urandom); tb[i] = W'($urandom);
      tc[i] = 1'($urandom); tm[i] = 1'($urandom);
    end
    while (got < 6 && cyc < 60) begin
      if (!started && out_valid) begin
        started = 1;
        stall_left = 5;
      end
      out_ready = (stall_left == 0);
      if (sent < 6) begin
        a = ta[sent]; b = tb[sent]; cin = tc[sent]; approx_en = tm[sent];
        in_valid = 1'b1;
      end else begin
        idle();
      end
      @(negedge clk);
      if (stall_left > 0) begin
        checks += 3;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready got %b want 0", in_ready);
        end
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL bp_hold_valid got %b want 1", out_valid);
        end
        if (q.size() == 0 || {out_approx, cout, sum} !== q[0]) begin
          errors++;
          $display("FAIL bp_hold_value got %h want %h",
                   {out_approx, cout, sum}, (q.size() > 0) ? q[0] : '0);
        end
        stall_left--;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_extra got %h want none", {cout, sum});
        end else begin
          if ({out_approx, cout, sum} !== q[0]) begin
            errors++;
            $display("FAIL bp_result_%0d got %h want %h", got,
                     {out_approx, cout, sum}, q[0]);
          end
          void'(q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back({approx_en, model(a, b, cin, approx_en)});
        sent++;
      end
      tick();
      cyc++;
    end
    checks += 2;
    if (got !== 6) begin
      errors++; $display("FAIL bp_count got %0d want 6", got);
    end
    if (started !== 1'b1) begin
      errors++; $display("FAIL bp_stall_seen got %b want 1", started);
    end
    idle();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL bp_dup_c%0d got %b want 0", c, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [W+1:0] q [$];
    int cyc = 0;
    bit pend = 0;
    while (cyc < 400) begin
      if (!pend && ($urandom_range(0, 3) != 0) && cyc < 360) begin
        a = W'($urandom); b = W'($urandom);
        cin = 1'($urandom); approx_en = 1'($urandom);
        pend = 1;
      end
      in_valid  = pend;
      out_ready = (cyc >= 360) || ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (q.size() == 0 || {out_approx, cout, sum} !== q[0]) begin
          errors++;
          $display("FAIL rnd_result_cyc%0d got %h want %h", cyc,
                   {out_approx, cout, sum}, (q.size() > 0) ? q[0] : '0);
        end
        if (out_ready && q.size() > 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back({approx_en, model(a, b, cin, approx_en)});
        pend = 0;
      end
      tick();
      cyc++;
    end
    idle();
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL rnd_drain got %0d left want 0", q.size());
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        a = W'($urandom); b = W'($urandom);
        cin = 1'($urandom); approx_en = 1'($urandom);
        in_valid = 1'b1;
      end else begin
        idle();
      end
      tick();
    end
    #2;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_pre_valid got %b want 1", out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid);
    end
    if (sum !== '0) begin
      errors++; $display("FAIL rst_mid_sum got %h want 0000", sum);
    end
    if (cout !== 1'b0) begin
      errors++; $display("FAIL rst_mid_cout got %b want 0", cout);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_stale_c%0d got %b want 0", c, out_valid);
      end
      tick();
    end
    a = 16'h0001; b = 16'h0001; cin = 1'b0; approx_en = 1'b0;
    in_valid = 1'b1;
    tick();
    idle();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (c == 4)) begin
        errors++;
        $display("FAIL rst_new_valid_c%0d got %b want %b", c, out_valid, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if ({cout, sum} !== 17'h00002) begin
          errors++; $display("FAIL rst_new_sum got %h want 00002", {cout, sum});
        end
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
